// File: rtl/alarm_match_unit.sv
// -----------------------------------------------------------------------------
// alarm_match_unit
//
// Holds the programmed alarm time (BCD hh:mm) and compares it with the running
// clock time from the time counter chain. It produces a single-cycle, registered
// `eq` strobe for the alarm light stage. It also handles arm/disarm, the daily
// re-arm after a fire, and a bounded snooze re-trigger.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : snooze path, SNOOZING state, snooze counter and snooze_active
//   undefined : snooze input ignored, snooze_active tied 0, FIRED -> ARMED only
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   alarm_enable   level, 1 = armed
//   load_alarm     strobe, capture alarm_hh_in / alarm_mm_in (validated)
//   alarm_hh_in    BCD hours to load (00..23)
//   alarm_mm_in    BCD minutes to load (00..59)
//   cur_hh/mm/ss   BCD current time
//   snooze         strobe, snooze request
//   eq             one-cycle match strobe
//   alarm_hh/mm    stored alarm time
//   snooze_active  high while snoozing
//   load_err       one-cycle strobe, rejected load
// -----------------------------------------------------------------------------
module alarm_match_unit #(
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_enable,
    input  logic       load_alarm,
    input  logic [7:0] alarm_hh_in,
    input  logic [7:0] alarm_mm_in,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    input  logic       snooze,
    output logic       eq,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic       snooze_active,
    output logic       load_err
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRED    = 2'd2,
        ST_SNOOZING = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRED    = 2'd2
    } state_t;
`endif

    // Both nibbles decimal and the value inside the 24h / 60min range.
    function automatic logic bcd_time_ok(input logic [7:0] hh, input logic [7:0] mm);
        return (hh[3:0] <= 4'd9) && (mm[3:0] <= 4'd9) &&
               (hh <= 8'h23) && (mm <= 8'h59);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] alarm_hh_q, alarm_hh_d;
    logic [7:0] alarm_mm_q, alarm_mm_d;
    logic [7:0] tgt_hh_q, tgt_hh_d;
    logic [7:0] tgt_mm_q, tgt_mm_d;
    logic       match_d_q;
    logic       eq_q, eq_d;
    logic       load_err_q, load_err_d;
    logic       match_s;
    logic       rise_s;
    logic       load_ok_s;

    assign match_s   = (cur_hh == tgt_hh_q) && (cur_mm == tgt_mm_q) && (cur_ss == 8'h00);
    assign rise_s    = match_s && !match_d_q;
    assign load_ok_s = bcd_time_ok(alarm_hh_in, alarm_mm_in);

`ifdef ALARM_SNOOZE_EN
    logic [3:0] snooze_cnt_q, snooze_cnt_d;
    logic       snooze_active_q;
    logic [7:0] snz_hh_s, snz_mm_s;

    function automatic logic [6:0] from_bcd(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return {t[3:0], 4'(v - t * 7'd10)};
    endfunction

    // Snooze target: current hh:mm plus SNOOZE_MIN, minutes carry into hours,
    // hours wrap at 24. Seconds are dropped so the new target fires at ss=00.
    always_comb begin
        logic [6:0] mm_sum;
        logic [6:0] hh_sum;
        mm_sum = from_bcd(cur_mm) + 7'(SNOOZE_MIN);
        hh_sum = from_bcd(cur_hh);
        if (mm_sum >= 7'd60) begin
            mm_sum = mm_sum - 7'd60;
            hh_sum = hh_sum + 7'd1;
        end else begin
            mm_sum = mm_sum;
        end
        if (hh_sum >= 7'd24) begin
            hh_sum = hh_sum - 7'd24;
        end else begin
            hh_sum = hh_sum;
        end
        snz_mm_s = to_bcd(mm_sum);
        snz_hh_s = to_bcd(hh_sum);
    end

    assign snooze_active = snooze_active_q;
`else
    // The snooze pin and sizing parameters have no function in this build.
    logic unused_snooze_s;
    assign unused_snooze_s = snooze;
    localparam int unused_cfg_lp = SNOOZE_MIN + MAX_SNOOZE;
    assign snooze_active = 1'b0;
`endif

    // Next-state logic; event priority is load > disable > snooze > match.
    always_comb begin
        state_d    = state_q;
        alarm_hh_d = alarm_hh_q;
        alarm_mm_d = alarm_mm_q;
        tgt_hh_d   = tgt_hh_q;
        tgt_mm_d   = tgt_mm_q;
        eq_d       = 1'b0;
        load_err_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif
        if (load_alarm) begin
            // A load consumes the cycle, so a coincident match edge gives no eq.
            if (load_ok_s) begin
                alarm_hh_d = alarm_hh_in;
                alarm_mm_d = alarm_mm_in;
                tgt_hh_d   = alarm_hh_in;
                tgt_mm_d   = alarm_mm_in;
                state_d    = alarm_enable ? ST_ARMED : ST_DISARMED;
`ifdef ALARM_SNOOZE_EN
                snooze_cnt_d = 4'd0;
`endif
            end else begin
                load_err_d = 1'b1;
            end
        end else if (!alarm_enable) begin
            // Disabling cancels any snooze and restores the real alarm target.
            state_d  = ST_DISARMED;
            tgt_hh_d = alarm_hh_q;
            tgt_mm_d = alarm_mm_q;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = 4'd0;
`endif
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    // match_d already tracks the target, so enabling inside
                    // the match second cannot produce a rising edge.
                    state_d  = ST_ARMED;
                    tgt_hh_d = alarm_hh_q;
                    tgt_mm_d = alarm_mm_q;
                end
                ST_ARMED: begin
                    if (rise_s) begin
                        eq_d    = 1'b1;
                        state_d = ST_FIRED;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt_d = 4'd0;
`endif
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_FIRED: begin
`ifdef ALARM_SNOOZE_EN
                    if (snooze && (snooze_cnt_q < 4'(MAX_SNOOZE))) begin
                        tgt_hh_d     = snz_hh_s;
                        tgt_mm_d     = snz_mm_s;
                        snooze_cnt_d = snooze_cnt_q + 4'd1;
                        state_d      = ST_SNOOZING;
                    end else if (!match_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_FIRED;
                    end
`else
                    if (!match_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_FIRED;
                    end
`endif
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZING: begin
                    if (rise_s) begin
                        eq_d     = 1'b1;
                        tgt_hh_d = alarm_hh_q;
                        tgt_mm_d = alarm_mm_q;
                        state_d  = ST_FIRED;
                    end else begin
                        state_d = ST_SNOOZING;
                    end
                end
`endif
                default: begin
                    state_d  = ST_DISARMED;
                    tgt_hh_d = alarm_hh_q;
                    tgt_mm_d = alarm_mm_q;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_DISARMED;
            alarm_hh_q <= 8'h00;
            alarm_mm_q <= 8'h00;
            tgt_hh_q   <= 8'h00;
            tgt_mm_q   <= 8'h00;
            match_d_q  <= 1'b0;
            eq_q       <= 1'b0;
            load_err_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q    <= 4'd0;
            snooze_active_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            alarm_hh_q <= alarm_hh_d;
            alarm_mm_q <= alarm_mm_d;
            tgt_hh_q   <= tgt_hh_d;
            tgt_mm_q   <= tgt_mm_d;
            match_d_q  <= match_s;
            eq_q       <= eq_d;
            load_err_q <= load_err_d;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q    <= snooze_cnt_d;
            snooze_active_q <= (state_d == ST_SNOOZING);
`endif
        end
    end

    assign eq       = eq_q;
    assign load_err = load_err_q;
    assign alarm_hh = alarm_hh_q;
    assign alarm_mm = alarm_mm_q;

endmodule

// File: tb/tb_alarm_match_unit.sv
module tb_alarm_match_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_enable;
    logic       load_alarm;
    logic [7:0] alarm_hh_in;
    logic [7:0] alarm_mm_in;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       snooze;
    logic       eq;
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       snooze_active;
    logic       load_err;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0] exp_q[$];
    string      tag_q[$];

    alarm_match_unit #(.SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_enable (alarm_enable),
        .load_alarm   (load_alarm),
        .alarm_hh_in  (alarm_hh_in),
        .alarm_mm_in  (alarm_mm_in),
        .cur_hh       (cur_hh),
        .cur_mm       (cur_mm),
        .cur_ss       (cur_ss),
        .snooze       (snooze),
        .eq           (eq),
        .alarm_hh     (alarm_hh),
        .alarm_mm     (alarm_mm),
        .snooze_active(snooze_active),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk8(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input logic obs, input logic exp, input string tag);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Push the expected {eq, load_err} for the stimulus now on the pins,
    // advance one clock, then pop and compare against the registered outputs.
    task automatic cyc(input logic e_eq, input logic e_err, input string tag);
        logic [1:0] e;
        string      t;
        exp_q.push_back({e_eq, e_err});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk1(eq, e[1], {t, "_eq"});
        chk1(load_err, e[0], {t, "_err"});
    endtask

    task automatic set_t(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hh = h;
        cur_mm = m;
        cur_ss = s;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic e_err,
                        input string tag);
        alarm_hh_in = h;
        alarm_mm_in = m;
        load_alarm  = 1'b1;
        cyc(1'b0, e_err, tag);
        load_alarm  = 1'b0;
    endtask

`ifdef ALARM_SNOOZE_EN
    logic [7:0] mm_pre[3] = '{8'h04, 8'h09, 8'h14};
    logic [7:0] mm_hit[3] = '{8'h05, 8'h10, 8'h15};
`endif

    initial begin
        reset        = 1'b1;
        alarm_enable = 1'b0;
        load_alarm   = 1'b0;
        alarm_hh_in  = 8'h00;
        alarm_mm_in  = 8'h00;
        snooze       = 1'b0;
        set_t(8'h12, 8'h00, 8'h00);

        // Reset state
        cyc(1'b0, 1'b0, "rst_a");
        cyc(1'b0, 1'b0, "rst_b");
        chk8(alarm_hh, 8'h00, "rst_alarm_hh");
        chk8(alarm_mm, 8'h00, "rst_alarm_mm");
        chk1(snooze_active, 1'b0, "rst_snz_act");

        // Arm and load 07:30, single eq one clock after ss reaches 00
        reset        = 1'b0;
        alarm_enable = 1'b1;
        cyc(1'b0, 1'b0, "enable");
        load(8'h07, 8'h30, 1'b0, "ld_0730");
        chk8(alarm_hh, 8'h07, "ld_alarm_hh");
        chk8(alarm_mm, 8'h30, "ld_alarm_mm");
        set_t(8'h07, 8'h29, 8'h59);
        cyc(1'b0, 1'b0, "t072959");
        set_t(8'h07, 8'h30, 8'h00);
        cyc(1'b1, 1'b0, "fire_0730");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "hold_ss00");
        set_t(8'h07, 8'h30, 8'h01);
        cyc(1'b0, 1'b0, "t073001_a");
        cyc(1'b0, 1'b0, "t073001_b");

        // Invalid loads leave the stored alarm untouched
        load(8'h24, 8'h00, 1'b1, "bad_hh24");
        chk8(alarm_hh, 8'h07, "bad24_alarm_hh");
        chk8(alarm_mm, 8'h30, "bad24_alarm_mm");
        load(8'h12, 8'h6A, 1'b1, "bad_mm6a");
        chk8(alarm_hh, 8'h07, "bad6a_alarm_hh");
        chk8(alarm_mm, 8'h30, "bad6a_alarm_mm");
        load(8'h1A, 8'h00, 1'b1, "bad_hh1a");
        cyc(1'b0, 1'b0, "err_one_cycle");

        // Daily re-arm: next 07:30:00 fires again
        set_t(8'h07, 8'h29, 8'h59);
        cyc(1'b0, 1'b0, "day2_pre");
        set_t(8'h07, 8'h30, 8'h00);
        cyc(1'b1, 1'b0, "day2_fire");

        // Disable, then enable inside the match second: no eq
        set_t(8'h07, 8'h29, 8'h59);
        alarm_enable = 1'b0;
        cyc(1'b0, 1'b0, "disable");
        set_t(8'h07, 8'h30, 8'h00);
        cyc(1'b0, 1'b0, "dis_match");
        alarm_enable = 1'b1;
        cyc(1'b0, 1'b0, "en_in_window_a");
        cyc(1'b0, 1'b0, "en_in_window_b");
        set_t(8'h07, 8'h30, 8'h01);
        cyc(1'b0, 1'b0, "en_after");
        set_t(8'h07, 8'h29, 8'h59);
        cyc(1'b0, 1'b0, "day3_pre");
        set_t(8'h07, 8'h30, 8'h00);
        cyc(1'b1, 1'b0, "day3_fire");

        // Load coincident with a match edge suppresses that eq
        load(8'h09, 8'h00, 1'b0, "ld_0900");
        set_t(8'h08, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t085959");
        set_t(8'h09, 8'h00, 8'h00);
        load(8'h09, 8'h00, 1'b0, "ld_on_edge");
        cyc(1'b0, 1'b0, "after_ld_edge_a");
        cyc(1'b0, 1'b0, "after_ld_edge_b");
        set_t(8'h09, 8'h00, 8'h01);
        cyc(1'b0, 1'b0, "t090001");

        // Reset in FIRED
        set_t(8'h08, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t085959_b");
        set_t(8'h09, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "fire_0900");
        reset = 1'b1;
        cyc(1'b0, 1'b0, "rst_fired");
        chk8(alarm_hh, 8'h00, "rstf_alarm_hh");
        chk8(alarm_mm, 8'h00, "rstf_alarm_mm");
        chk1(snooze_active, 1'b0, "rstf_snz_act");
        reset = 1'b0;

`ifdef ALARM_SNOOZE_EN
        // Snooze across midnight: 23:58 + 5 = 00:03
        load(8'h23, 8'h58, 1'b0, "ld_2358");
        set_t(8'h23, 8'h57, 8'h59);
        cyc(1'b0, 1'b0, "t235759");
        set_t(8'h23, 8'h58, 8'h00);
        cyc(1'b1, 1'b0, "fire_2358");
        cyc(1'b0, 1'b0, "fired_hold");
        snooze = 1'b1;
        cyc(1'b0, 1'b0, "snz_2358");
        snooze = 1'b0;
        chk1(snooze_active, 1'b1, "snz_act_on");
        set_t(8'h23, 8'h58, 8'h10);
        cyc(1'b0, 1'b0, "t235810");
        chk1(snooze_active, 1'b1, "snz_act_hold");
        set_t(8'h00, 8'h02, 8'h59);
        cyc(1'b0, 1'b0, "t000259");
        set_t(8'h00, 8'h03, 8'h00);
        cyc(1'b1, 1'b0, "fire_0003");
        chk1(snooze_active, 1'b0, "snz_act_off");
        cyc(1'b0, 1'b0, "post_0003");
        set_t(8'h23, 8'h57, 8'h59);
        cyc(1'b0, 1'b0, "t235759_b");
        set_t(8'h23, 8'h58, 8'h00);
        cyc(1'b1, 1'b0, "refire_2358");

        // Three snoozes accepted, the fourth ignored
        load(8'h06, 8'h00, 1'b0, "ld_0600");
        set_t(8'h05, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t055959");
        set_t(8'h06, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "fire_0600");
        snooze = 1'b1;
        cyc(1'b0, 1'b0, "snz_n1");
        snooze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_t(8'h06, mm_pre[k], 8'h59);
            cyc(1'b0, 1'b0, "snz_pre");
            set_t(8'h06, mm_hit[k], 8'h00);
            cyc(1'b1, 1'b0, "snz_fire");
            snooze = 1'b1;
            cyc(1'b0, 1'b0, "snz_req");
            snooze = 1'b0;
            chk1(snooze_active, (k < 2) ? 1'b1 : 1'b0, "snz_cnt_limit");
        end
        set_t(8'h06, 8'h19, 8'h59);
        cyc(1'b0, 1'b0, "t061959");
        set_t(8'h06, 8'h20, 8'h00);
        cyc(1'b0, 1'b0, "no_fire_0620");
        chk1(snooze_active, 1'b0, "snz_act_0620");

        // Disable while snoozing cancels the snooze
        load(8'h06, 8'h00, 1'b0, "ld_0600_b");
        set_t(8'h05, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t055959_b");
        set_t(8'h06, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "fire_0600_b");
        snooze = 1'b1;
        cyc(1'b0, 1'b0, "snz_b");
        snooze = 1'b0;
        chk1(snooze_active, 1'b1, "snz_b_act");
        alarm_enable = 1'b0;
        cyc(1'b0, 1'b0, "dis_snoozing");
        chk1(snooze_active, 1'b0, "dis_snz_act");
        set_t(8'h06, 8'h04, 8'h59);
        cyc(1'b0, 1'b0, "t060459");
        set_t(8'h06, 8'h05, 8'h00);
        cyc(1'b0, 1'b0, "dis_0605");
        alarm_enable = 1'b1;
        cyc(1'b0, 1'b0, "en_0605_a");
        cyc(1'b0, 1'b0, "en_0605_b");
        set_t(8'h05, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t055959_c");
        set_t(8'h06, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "nextday_0600");
`else
        // Snooze has no effect in this build
        load(8'h06, 8'h00, 1'b0, "ld_0600");
        set_t(8'h05, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t055959");
        set_t(8'h06, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "fire_0600");
        snooze = 1'b1;
        cyc(1'b0, 1'b0, "snz_ignored");
        snooze = 1'b0;
        chk1(snooze_active, 1'b0, "snz_act_tied");
        set_t(8'h06, 8'h04, 8'h59);
        cyc(1'b0, 1'b0, "t060459");
        set_t(8'h06, 8'h05, 8'h00);
        cyc(1'b0, 1'b0, "no_fire_0605");
        set_t(8'h05, 8'h59, 8'h59);
        cyc(1'b0, 1'b0, "t055959_b");
        set_t(8'h06, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, "nextday_0600");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
